// File: rtl/pe_stream_tx.sv
// Streams a block of global-buffer words into one PE input channel through a 2-entry prefetch FIFO.
// Optional feature: define TX_CHECKSUM_EN to add the checksum output and its accumulator.
module pe_stream_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int PARA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [PARA_WIDTH-1:0] length,
    output logic                  start_load,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  pe_fifo_full,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_en,
`ifdef TX_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [PARA_WIDTH-1:0] len_q;
    logic [PARA_WIDTH-1:0] rd_cnt_q;
    logic [PARA_WIDTH-1:0] sent_q;
    logic                  pend_q;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [DATA_WIDTH-1:0] last_q;
    logic                  xfer;
    logic [2:0]            occ;

    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        mem_rd_en  = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        xfer       = (state_q == STREAM) && (count_q != 2'd0) && !pe_fifo_full;
        // Occupancy after this cycle's pop, so a read can replace a word leaving in the same cycle.
        occ        = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, xfer};
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                start_load = 1'b1;
                if (len_q != '0) begin
                    mem_rd_en = 1'b1;
                    state_d   = STREAM;
                end else begin
                    state_d = DONE;
                end
            end
            STREAM: begin
                busy = 1'b1;
                if ((rd_cnt_q < len_q) && (occ < 3'd2)) mem_rd_en = 1'b1;
                if ((sent_q + {{(PARA_WIDTH-1){1'b0}}, xfer}) == len_q) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out_en = xfer;
    assign data_out    = xfer ? fifo_q[rd_ptr_q] : last_q;
    assign mem_addr    = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            rd_cnt_q <= '0;
            sent_q   <= '0;
            pend_q   <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            last_q   <= '0;
            for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= mem_rd_en;
            if ((state_q == IDLE) && start) begin
                addr_q   <= base_addr;
                len_q    <= length;
                rd_cnt_q <= '0;
                sent_q   <= '0;
            end
            if (mem_rd_en) begin
                addr_q   <= addr_q + 1'b1;
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (pend_q) begin
                fifo_q[wr_ptr_q] <= mem_rd_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (xfer) begin
                rd_ptr_q <= ~rd_ptr_q;
                last_q   <= fifo_q[rd_ptr_q];
                sent_q   <= sent_q + 1'b1;
            end
            count_q <= count_q + {1'b0, pend_q} - {1'b0, xfer};
        end
    end

`ifdef TX_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst)                  sum_q <= '0;
        else if (state_q == LOAD) sum_q <= '0;
        else if (xfer)            sum_q <= sum_q + fifo_q[rd_ptr_q];
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_pe_stream_tx.sv
// Directed bench for pe_stream_tx: buffer model plus address/data scoreboards checked with immediate assertions.
module tb_pe_stream_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  length;
    logic        start_load;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rd_data;
    logic        pe_fifo_full;
    logic [15:0] data_out;
    logic        data_out_en;
    logic        busy;
    logic        done;
`ifdef TX_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int compared   = 0;
    int mismatched = 0;
    int rd_count   = 0;
    logic [15:0] mem [256];
    logic [7:0]  addr_q [$];
    logic [15:0] data_q [$];
    logic [15:0] exp_sum;

    pe_stream_tx #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .PARA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .start_load   (start_load),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .pe_fifo_full (pe_fifo_full),
        .data_out     (data_out),
        .data_out_en  (data_out_en),
`ifdef TX_CHECKSUM_EN
        .checksum     (checksum),
`endif
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Buffer read port: data valid one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        else           mem_rd_data <= 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                rd_count++;
                if (addr_q.size() == 0) chk("spurious_read", 32'(mem_addr), 32'hFFFF_FFFF);
                else chk("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            end
            if (data_out_en) begin
                chk("en_while_full", 32'(pe_fifo_full), 32'd0);
                if (data_q.size() == 0) chk("spurious_word", 32'(data_out), 32'hFFFF_FFFF);
                else chk("data_out", 32'(data_out), 32'(data_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] b, input logic [7:0] n);
        logic [7:0] a;
        start     = 1'b1;
        base_addr = b;
        length    = n;
        exp_sum   = '0;
        rd_count  = 0;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 8'(i);
            addr_q.push_back(a);
            data_q.push_back(mem[a]);
            exp_sum = exp_sum + mem[a];
        end
    endtask

    task automatic wait_done(input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            step();
            #1;
            if (done) seen = 1'b1;
        end
        chk("done_within_bound", 32'(seen), 32'd1);
    endtask

    task automatic sb_empty(input int reads);
        chk("sb_addr_empty", 32'(addr_q.size()), 32'd0);
        chk("sb_data_empty", 32'(data_q.size()), 32'd0);
        chk("read_count", 32'(rd_count), 32'(reads));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 16'(k * 37 + 16'h0105);
        for (int i = 0; i < 6; i++) mem[8'h10 + i] = 16'(i + 1);
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; pe_fifo_full = 1'b0;
        step(); step();
        #1;
        chk("rst_start_load", 32'(start_load), 0);
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_out_en", 32'(data_out_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
`ifdef TX_CHECKSUM_EN
        chk("rst_checksum", 32'(checksum), 0);
`endif
        rst = 1'b0;

        // Basic block: base 0x10, length 6, words 1..6.
        step(); launch(8'h10, 8'd6);
        step(); start = 1'b0; #1;
        chk("t1_c1_start_load", 32'(start_load), 1);
        chk("t1_c1_rd_en", 32'(mem_rd_en), 1);
        chk("t1_c1_busy", 32'(busy), 1);
        step(); #1;
        chk("t1_c2_out_en", 32'(data_out_en), 0);
        chk("t1_c2_start_load", 32'(start_load), 0);
        for (int c = 3; c <= 8; c++) begin
            step(); #1;
            chk("t1_stream_en", 32'(data_out_en), 1);
            chk("t1_stream_word", 32'(data_out), 32'(c - 2));
        end
        step(); #1;
        chk("t1_c9_done", 32'(done), 1);
        chk("t1_c9_busy", 32'(busy), 0);
        step(); #1;
        chk("t1_c10_done", 32'(done), 0);
        chk("t1_hold_last", 32'(data_out), 6);
`ifdef TX_CHECKSUM_EN
        chk("t1_checksum", 32'(checksum), 21);
`endif
        sb_empty(6);

        // Stall: full high in cycles 4..8.
        step(); launch(8'h10, 8'd6);
        step(); start = 1'b0;
        step();
        step(); #1;
        chk("t2_c3_word", 32'(data_out), 1);
        for (int c = 4; c <= 8; c++) begin
            step(); pe_fifo_full = 1'b1; #1;
            chk("t2_stall_en", 32'(data_out_en), 0);
            chk("t2_stall_hold", 32'(data_out), 1);
            if (c >= 5) chk("t2_stall_no_read", 32'(mem_rd_en), 0);
        end
        step(); pe_fifo_full = 1'b0; #1;
        chk("t2_resume_en", 32'(data_out_en), 1);
        chk("t2_resume_word", 32'(data_out), 2);
        wait_done(20);
        step();
        sb_empty(6);
`ifdef TX_CHECKSUM_EN
        chk("t2_checksum", 32'(checksum), 32'(exp_sum));
`endif

        // Address wrap.
        step(); launch(8'hFE, 8'd4);
        step(); start = 1'b0;
        wait_done(20);
        step();
        sb_empty(4);
`ifdef TX_CHECKSUM_EN
        chk("t3_checksum", 32'(checksum), 32'(exp_sum));
`endif

        // Zero length.
        step(); launch(8'h30, 8'd0);
        step(); start = 1'b0; #1;
        chk("t4_c1_start_load", 32'(start_load), 1);
        chk("t4_c1_rd_en", 32'(mem_rd_en), 0);
        step(); #1;
        chk("t4_c2_done", 32'(done), 1);
        step(); #1;
        chk("t4_c3_done", 32'(done), 0);
        sb_empty(0);

        // Start while busy is ignored.
        step(); launch(8'h10, 8'd6);
        step(); start = 1'b0;
        step(); step(); step();
        step(); start = 1'b1; base_addr = 8'h80; length = 8'd3; #1;
        chk("t5_busy_during", 32'(busy), 1);
        chk("t5_no_reload", 32'(start_load), 0);
        step(); start = 1'b0;
        step(); step(); #1;
        chk("t5_c8_en", 32'(data_out_en), 1);
        step(); #1;
        chk("t5_c9_done", 32'(done), 1);
        for (int c = 10; c <= 12; c++) begin
            step(); #1;
            chk("t5_idle_start_load", 32'(start_load), 0);
            chk("t5_idle_busy", 32'(busy), 0);
        end
        sb_empty(6);

        // Reset during word 3 of 9, then a fresh 2-word block.
        step(); launch(8'h40, 8'd9);
        step(); start = 1'b0;
        step(); step(); step();
        step(); #1;
        chk("t6_word3", 32'(data_out), 32'(mem[8'h42]));
        rst = 1'b1;
        step(); rst = 1'b0; addr_q.delete(); data_q.delete(); #1;
        chk("t6_rst_start_load", 32'(start_load), 0);
        chk("t6_rst_rd_en", 32'(mem_rd_en), 0);
        chk("t6_rst_addr", 32'(mem_addr), 0);
        chk("t6_rst_data_out", 32'(data_out), 0);
        chk("t6_rst_out_en", 32'(data_out_en), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_done", 32'(done), 0);
`ifdef TX_CHECKSUM_EN
        chk("t6_rst_checksum", 32'(checksum), 0);
`endif
        step(); #1; chk("t6_no_done_a", 32'(done), 0);
        step(); #1; chk("t6_no_done_b", 32'(done), 0);
        step(); launch(8'h20, 8'd2);
        step(); start = 1'b0;
        wait_done(20);
        step();
        sb_empty(2);
`ifdef TX_CHECKSUM_EN
        chk("t6_checksum", 32'(checksum), 32'(exp_sum));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
